// File: rtl/mem_access_scheduler.sv
// ============================================================================
//  Module   : mem_access_scheduler
//  Purpose  : Round-robin scheduler that shares the memory latency pipelines
//             between the SIMD cores (segments). One access is granted per
//             cycle at most; each grant is tagged with the shared-level or
//             the DRAM latency. Every outstanding access is timed by a per-core
//             countdown that ends in a one-cycle completion pulse. The number
//             of DRAM accesses in flight is capped at MAX_DRAM_OUT.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          in   1          clock
//    reset        in   1          synchronous, active-high reset
//    stall        in   1          global freeze (state holds, pulses masked)
//    req          in   NUM_CORE   per-core request, held until granted
//    req_dram     in   NUM_CORE   1 = DRAM access, 0 = shared level
//    grant        out  NUM_CORE   one-hot grant pulse (registered)
//    grant_valid  out  1          OR of grant
//    grant_seg    out  CORE_LOG   index of granted core (0 when no grant)
//    delay        out  DELAY_W    latency tagged on the grant (0 when none)
//    busy         out  NUM_CORE   core has an outstanding access
//    done         out  NUM_CORE   completion pulse per core
//  Optional (macro MEM_SCHED_PERF_EN):
//    grant_count      out 32      saturating number of grants
//    conflict_cycles  out 32      saturating number of non-stalled cycles in
//                                 which a free requester was not granted
// ============================================================================
`default_nettype none

module mem_access_scheduler #(
  parameter int NUM_CORE     = 4,
  parameter int CORE_LOG     = 2,
  parameter int DELAY_W      = 10,
  parameter int SHARED_DELAY = 1,
  parameter int DRAM_DELAY   = 400,
  parameter int MAX_DRAM_OUT = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic [NUM_CORE-1:0] req,
  input  logic [NUM_CORE-1:0] req_dram,
  output logic [NUM_CORE-1:0] grant,
  output logic                grant_valid,
  output logic [CORE_LOG-1:0] grant_seg,
  output logic [DELAY_W-1:0]  delay,
  output logic [NUM_CORE-1:0] busy,
  output logic [NUM_CORE-1:0] done
`ifdef MEM_SCHED_PERF_EN
  ,
  output logic [31:0]         grant_count,
  output logic [31:0]         conflict_cycles
`endif
);

  // Wide enough to count every core as a DRAM user.
  localparam int DO_W = $clog2(NUM_CORE + 1);

  localparam logic [DELAY_W-1:0] SHARED_LAT = DELAY_W'(SHARED_DELAY);
  localparam logic [DELAY_W-1:0] DRAM_LAT   = DELAY_W'(DRAM_DELAY);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } core_state_e;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  core_state_e         state_q [NUM_CORE];
  core_state_e         state_d [NUM_CORE];
  logic [DELAY_W-1:0]  cnt_q   [NUM_CORE];
  logic [DELAY_W-1:0]  cnt_d   [NUM_CORE];
  logic [NUM_CORE-1:0] dram_q, dram_d;       // outstanding access is DRAM
  logic [CORE_LOG-1:0] ptr_q, ptr_d;
  logic [DO_W-1:0]     dram_out_q, dram_out_d;
  logic [NUM_CORE-1:0] grant_q, grant_d;
  logic [CORE_LOG-1:0] grant_seg_q, grant_seg_d;
  logic [DELAY_W-1:0]  delay_q, delay_d;

  // --------------------------------------------------------------------------
  // Completion / eligibility
  // --------------------------------------------------------------------------
  logic [NUM_CORE-1:0] busy_w;
  logic [NUM_CORE-1:0] done_raw;   // counter expired, independent of stall
  logic [NUM_CORE-1:0] elig;
  logic                dram_done_any;
  logic                cap_ok;

  always_comb begin
    for (int i = 0; i < NUM_CORE; i++) begin
      busy_w[i]   = (state_q[i] == ST_WAIT);
      done_raw[i] = busy_w[i] && (cnt_q[i] == '0);
    end
  end

  assign dram_done_any = |(done_raw & dram_q);

  // A DRAM slot being released this cycle can be reused at the same edge.
  assign cap_ok = (int'(dram_out_q) < MAX_DRAM_OUT) || dram_done_any;

  // A busy core becomes eligible again in its done cycle (back-to-back).
  assign elig = req & (~busy_w | done_raw) & (~req_dram | {NUM_CORE{cap_ok}});

  // --------------------------------------------------------------------------
  // Round-robin selection starting at ptr
  // --------------------------------------------------------------------------
  logic                sel_found;
  logic [CORE_LOG-1:0] sel_idx;
  logic [CORE_LOG-1:0] cand_idx;
  logic [NUM_CORE-1:0] sel_onehot;

  always_comb begin
    sel_found  = 1'b0;
    sel_idx    = '0;
    cand_idx   = '0;
    sel_onehot = '0;
    for (int k = 0; k < NUM_CORE; k++) begin
      cand_idx = CORE_LOG'((int'(ptr_q) + k) % NUM_CORE);
      if (!sel_found && elig[cand_idx]) begin
        sel_found = 1'b1;
        sel_idx   = cand_idx;
      end
    end
    if (sel_found) begin
      sel_onehot[sel_idx] = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  logic [DO_W-1:0] dram_dec;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dram_d      = dram_q;
    ptr_d       = ptr_q;
    dram_out_d  = dram_out_q;
    grant_d     = '0;
    grant_seg_d = '0;
    delay_d     = '0;
    dram_dec    = '0;

    // A stalled edge freezes all state; only the grant pulse is dropped.
    if (!stall) begin
      for (int i = 0; i < NUM_CORE; i++) begin
        if (busy_w[i]) begin
          if (done_raw[i]) begin
            state_d[i] = ST_IDLE;
            if (dram_q[i]) begin
              dram_dec = dram_dec + DO_W'(1);
            end
          end else begin
            cnt_d[i] = cnt_q[i] - DELAY_W'(1);
          end
        end
      end

      // Applied after the countdown so a re-grant in the done cycle wins.
      if (sel_found) begin
        state_d[sel_idx] = ST_WAIT;
        cnt_d[sel_idx]   = req_dram[sel_idx] ? DRAM_LAT : SHARED_LAT;
        dram_d[sel_idx]  = req_dram[sel_idx];
        grant_d          = sel_onehot;
        grant_seg_d      = sel_idx;
        delay_d          = req_dram[sel_idx] ? DRAM_LAT : SHARED_LAT;
        if (int'(sel_idx) == NUM_CORE - 1) begin
          ptr_d = '0;
        end else begin
          ptr_d = sel_idx + CORE_LOG'(1);
        end
      end

      dram_out_d = dram_out_q - dram_dec +
                   ((sel_found && req_dram[sel_idx]) ? DO_W'(1) : DO_W'(0));
    end
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CORE; i++) begin
        state_q[i] <= ST_IDLE;
        cnt_q[i]   <= '0;
      end
      dram_q      <= '0;
      ptr_q       <= '0;
      dram_out_q  <= '0;
      grant_q     <= '0;
      grant_seg_q <= '0;
      delay_q     <= '0;
    end else begin
      for (int i = 0; i < NUM_CORE; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      dram_q      <= dram_d;
      ptr_q       <= ptr_d;
      dram_out_q  <= dram_out_d;
      grant_q     <= grant_d;
      grant_seg_q <= grant_seg_d;
      delay_q     <= delay_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: pulses are masked while stalled
  // --------------------------------------------------------------------------
  assign grant       = stall ? '0 : grant_q;
  assign grant_valid = ~stall & (|grant_q);
  assign grant_seg   = stall ? '0 : grant_seg_q;
  assign delay       = stall ? '0 : delay_q;
  assign busy        = busy_w;
  assign done        = stall ? '0 : done_raw;

`ifdef MEM_SCHED_PERF_EN
  // --------------------------------------------------------------------------
  // Performance counters (saturating)
  // --------------------------------------------------------------------------
  logic [31:0] grant_count_q, grant_count_d;
  logic [31:0] conflict_q, conflict_d;
  logic        conflict_w;

  // A free requester that was not picked, whether by arbitration or DRAM cap.
  assign conflict_w = |(req & ~busy_w & ~sel_onehot);

  always_comb begin
    grant_count_d = grant_count_q;
    conflict_d    = conflict_q;
    if (!stall) begin
      if (sel_found && (grant_count_q != '1)) begin
        grant_count_d = grant_count_q + 32'd1;
      end
      if (conflict_w && (conflict_q != '1)) begin
        conflict_d = conflict_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      grant_count_q <= '0;
      conflict_q    <= '0;
    end else begin
      grant_count_q <= grant_count_d;
      conflict_q    <= conflict_d;
    end
  end

  assign grant_count     = grant_count_q;
  assign conflict_cycles = conflict_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_access_scheduler.sv
// ============================================================================
//  Module   : tb_mem_access_scheduler
//  Purpose  : Directed self-checking bench for mem_access_scheduler with
//             hand-computed expected values (default parameters).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_access_scheduler;

  logic       clk;
  logic       reset;
  logic       stall;
  logic [3:0] req;
  logic [3:0] req_dram;
  logic [3:0] grant;
  logic       grant_valid;
  logic [1:0] grant_seg;
  logic [9:0] delay;
  logic [3:0] busy;
  logic [3:0] done;
`ifdef MEM_SCHED_PERF_EN
  logic [31:0] grant_count;
  logic [31:0] conflict_cycles;
`endif

  int vectors;
  int miscompares;

  mem_access_scheduler dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .req         (req),
    .req_dram    (req_dram),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_seg   (grant_seg),
    .delay       (delay),
    .busy        (busy),
    .done        (done)
`ifdef MEM_SCHED_PERF_EN
    ,
    .grant_count     (grant_count),
    .conflict_cycles (conflict_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and sample 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    int n;
    int nd;
    int busy_cnt;
    int bad;
    int dones;
    bit got;

    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    stall       = 1'b0;
    req         = 4'b0000;
    req_dram    = 4'b0000;

    // ---------------- reset state ----------------
    step(); step();
    chk("rst_grant", grant, 0);
    chk("rst_grant_valid", grant_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_delay", delay, 0);
    reset = 1'b0;
    step();

    // ---------------- single shared access on core 0 ----------------
    req = 4'b0001; req_dram = 4'b0000;
    step();
    chk("sh_grant", grant, 4'b0001);
    chk("sh_grant_valid", grant_valid, 1);
    chk("sh_grant_seg", grant_seg, 0);
    chk("sh_delay", delay, 1);
    chk("sh_busy_g", busy, 4'b0001);
    chk("sh_done_g", done, 0);
    req = 4'b0000;
    step();
    chk("sh_done", done, 4'b0001);
    chk("sh_busy_d", busy, 4'b0001);
    chk("sh_grant_off", grant_valid, 0);
    chk("sh_seg_off", grant_seg, 0);
    step();
    chk("sh_busy_end", busy, 0);
    chk("sh_done_end", done, 0);

    // ---------------- DRAM access on core 2 (ptr = 1) ----------------
    req = 4'b0100; req_dram = 4'b0100;
    step();
    chk("dr_grant_seg", grant_seg, 2);
    chk("dr_delay", delay, 400);
    chk("dr_grant", grant, 4'b0100);
    req = 4'b0000; req_dram = 4'b0000;
    n = 0; busy_cnt = 1; got = 0;
    while (n < 500 && !got) begin
      step(); n++;
      if (busy[2]) busy_cnt++;
      if (done[2]) got = 1;
    end
    chk("dr_done_lat", n, 400);
    chk("dr_busy_len", busy_cnt, 401);
    step();
    chk("dr_busy_end", busy, 0);

    // ---------------- all four shared, round-robin from ptr = 0 ----------------
    // ptr is 3 now; one grant to core 3 wraps it to 0.
    req = 4'b1000; step(); req = 4'b0000;
    chk("rr_pre", grant, 4'b1000);
    step(); step();
    req = 4'b1111; req_dram = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("rr_grant%0d", k), grant, 32'(4'b0001 << k));
      req = req & ~grant;
    end
    step(); step();
    req = 4'b0011;
    step();
    chk("rr_wrap", grant, 4'b0001);
    req = 4'b0010;
    step();
    chk("rr_next", grant, 4'b0010);
    req = 4'b0000;
    step(); step();

    // ---------------- DRAM cap with cores 0,1,2 (ptr 2 -> 0 first) ----------------
    req = 4'b1000; step(); req = 4'b0000;
    step(); step();
    req = 4'b0111; req_dram = 4'b0111;
    step();
    chk("cap_g0", grant, 4'b0001);
    req = 4'b0110; req_dram = 4'b0110;
    step();
    chk("cap_g1", grant, 4'b0010);
    req = 4'b0100; req_dram = 4'b0100;
    n = 1; nd = -1;
    while (n < 600) begin
      step(); n++;
      if (done[0]) nd = n;
      if (grant != 4'b0000) break;
    end
    chk("cap_done0", nd, 400);
    chk("cap_g2_cycle", n, 401);
    chk("cap_g2", grant, 4'b0100);
    chk("cap_g2_delay", delay, 400);
    chk("cap_g2_busy", busy, 4'b0110);
    chk("cap_g2_done1", done, 4'b0010);
    // Two DRAM still counted, but core 1's done frees a slot this cycle.
    req = 4'b1000; req_dram = 4'b1000;
    step();
    chk("cap_g3_samecycle", grant, 4'b1000);
    req = 4'b0000; req_dram = 4'b0000;
    step(); step();

    // ---------------- reset with cores 2,3 DRAM in flight ----------------
    chk("rr_inflight_busy", busy, 4'b1100);
    reset = 1'b1;
    step();
    chk("mr_busy", busy, 0);
    chk("mr_done", done, 0);
    reset = 1'b0;
    dones = 0;
    for (int k = 0; k < 450; k++) begin
      step();
      if (done != 4'b0000) dones++;
    end
    chk("mr_no_done", dones, 0);
    req = 4'b0100; req_dram = 4'b0100;
    step();
    chk("mr_regrant", grant, 4'b0100);
    chk("mr_regrant_delay", delay, 400);
    req = 4'b0000; req_dram = 4'b0000;
    n = 0; got = 0;
    while (n < 500 && !got) begin
      step(); n++;
      if (done[2]) got = 1;
    end
    chk("mr_done_lat", n, 400);
    step();

    // ---------------- stall during DRAM countdown on core 0 ----------------
    req = 4'b0001; req_dram = 4'b0001;
    step();
    chk("st_grant", grant, 4'b0001);
    req = 4'b0000; req_dram = 4'b0000;
    n = 0; bad = 0; got = 0;
    while (n < 600 && !got) begin
      if (n == 100) begin
        stall = 1'b1;
        req   = 4'b0010;
      end
      if (n == 110) stall = 1'b0;
      step(); n++;
      if (stall && (grant != 4'b0000 || done != 4'b0000 || grant_valid)) bad++;
      if (n == 111) begin
        chk("st_release_grant", grant, 4'b0010);
        req = 4'b0000;
      end
      if (done[0]) got = 1;
    end
    chk("st_quiet", bad, 0);
    chk("st_done_lat", n, 410);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
